score_uart_tx: RTL and testbench

- Serial transmitter for the game's unused `tx` pin.
- On a `send` pulse it snapshots the 20-bit score and converts it to 7 decimal digits.
- It then transmits them as ASCII followed by CR LF, 8N1, LSB first.
- Intended instantiation: in top, with `send` driven by the 60 Hz frame strobe or a score-change event; `tx` replaces the constant 0.

---
 rtl/score_uart_pkg.sv | 23 ++
 rtl/bin2bcd_serial.sv | 71 +++++++
 rtl/score_uart_tx.sv | 185 ++++++++++++++++++
 tb/tb_score_uart_tx.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/score_uart_pkg.sv
// Shared types and constants for the score UART transmitter and its BCD converter.
package score_uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CONV,
        LOAD,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    localparam logic [7:0] ASCII_ZERO = 8'h30;
    localparam logic [7:0] ASCII_CR   = 8'h0D;
    localparam logic [7:0] ASCII_LF   = 8'h0A;

    // Clock cycles per line bit, rounded to the nearest integer.
    function automatic int calc_baud_div(input int clk_hz, input int baud);
        return (clk_hz + baud / 2) / baud;
    endfunction

endpackage

// File: rtl/bin2bcd_serial.sv
// Serial double-dabble binary to BCD converter.
// A start pulse loads bin and performs the first shift on the same edge, so the
// result is complete after BIN_W edges; done pulses for one cycle once bcd is final.
// bcd holds its value until the next start.
module bin2bcd_serial #(
    parameter int BIN_W  = 20,
    parameter int DIGITS = 7
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [BIN_W-1:0]      bin,
    output logic [DIGITS*4-1:0]   bcd,
    output logic                  done
);

    localparam int BCD_W = DIGITS * 4;
    localparam int SR_W  = BCD_W + BIN_W;
    localparam int CNT_W = $clog2(BIN_W + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIN_W - 1);

    logic [SR_W-1:0]  sr_reg;
    logic [SR_W-1:0]  sr_src;
    logic [SR_W-1:0]  sr_step;
    logic [BCD_W-1:0] adj;
    logic [CNT_W-1:0] cnt_reg;
    logic             active_reg;
    logic             done_reg;

    // On start the step operates on the freshly loaded value instead of the register.
    assign sr_src = start ? {{BCD_W{1'b0}}, bin} : sr_reg;

    // Add-3 correction for every digit that would overflow past 9 when doubled.
    generate
        for (genvar gi = 0; gi < DIGITS; gi++) begin : g_adj
            logic [3:0] digit;
            assign digit          = sr_src[BIN_W + gi*4 +: 4];
            assign adj[gi*4 +: 4] = (digit >= 4'd5) ? digit + 4'd3 : digit;
        end
    endgenerate

    assign sr_step = {adj, sr_src[BIN_W-1:0]} << 1;

    // One correct-and-shift step per cycle while a conversion is running.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr_reg     <= '0;
            cnt_reg    <= '0;
            active_reg <= 1'b0;
            done_reg   <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            if (start) begin
                sr_reg     <= sr_step;
                cnt_reg    <= CNT_W'(1);
                active_reg <= 1'b1;
            end else if (active_reg) begin
                sr_reg  <= sr_step;
                cnt_reg <= cnt_reg + CNT_W'(1);
                if (cnt_reg == CNT_LAST) begin
                    active_reg <= 1'b0;
                    done_reg   <= 1'b1;
                end
            end
        end
    end

    assign bcd  = sr_reg[SR_W-1 -: BCD_W];
    assign done = done_reg;

endmodule

// File: rtl/score_uart_tx.sv
// Score transmitter: on send, converts the 20-bit score to DIGITS decimal digits
// and sends them as ASCII followed by CR LF, 8N1, LSB first.
// Optional macro SCORE_UART_TX_PARITY_EN adds an even-parity bit after bit 7.
module score_uart_tx
    import score_uart_pkg::*;
#(
    parameter int CLK_HZ = 12000000,
    parameter int BAUD   = 115200,
    parameter int DIGITS = 7
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [19:0] score,
    input  logic        send,
    output logic        busy,
    output logic        tx
);

    localparam int BAUD_DIV = calc_baud_div(CLK_HZ, BAUD);
    localparam int BAUD_W   = $clog2(BAUD_DIV + 1);
    localparam int NBYTES   = DIGITS + 2;
    localparam int BYTE_W   = $clog2(NBYTES);
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(BAUD_DIV - 1);
    localparam logic [BYTE_W-1:0] BYTE_LAST = BYTE_W'(NBYTES - 1);

    state_t              state_reg, state_next;
    logic [BAUD_W-1:0]   baud_reg, baud_next;
    logic [2:0]          bit_reg, bit_next;
    logic [BYTE_W-1:0]   byte_reg, byte_next;
    logic [7:0]          shreg_reg, shreg_next;
    logic                tx_reg, tx_next;
`ifdef SCORE_UART_TX_PARITY_EN
    logic                par_reg, par_next;
`endif
    logic                baud_end;
    logic                conv_start;
    logic                conv_done;
    logic [DIGITS*4-1:0] bcd;
    logic [7:0]          msg_bytes [NBYTES];

    bin2bcd_serial #(
        .BIN_W  (20),
        .DIGITS (DIGITS)
    ) u_bcd (
        .clk   (clk),
        .rst_n (rst_n),
        .start (conv_start),
        .bin   (score),
        .bcd   (bcd),
        .done  (conv_done)
    );

    // Message layout: digits most significant first, then CR, then LF.
    generate
        for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
            assign msg_bytes[gi] = ASCII_ZERO + {4'h0, bcd[(DIGITS-1-gi)*4 +: 4]};
        end
    endgenerate
    assign msg_bytes[DIGITS]     = ASCII_CR;
    assign msg_bytes[DIGITS + 1] = ASCII_LF;

    // State and datapath registers; tx idles high and is always taken from a flop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            baud_reg  <= '0;
            bit_reg   <= '0;
            byte_reg  <= '0;
            shreg_reg <= '0;
            tx_reg    <= 1'b1;
`ifdef SCORE_UART_TX_PARITY_EN
            par_reg   <= 1'b0;
`endif
        end else begin
            state_reg <= state_next;
            baud_reg  <= baud_next;
            bit_reg   <= bit_next;
            byte_reg  <= byte_next;
            shreg_reg <= shreg_next;
            tx_reg    <= tx_next;
`ifdef SCORE_UART_TX_PARITY_EN
            par_reg   <= par_next;
`endif
        end
    end

    // Next-state, counter and line-level logic; tx_next reflects the current state.
    always_comb begin
        state_next = state_reg;
        baud_next  = baud_reg;
        bit_next   = bit_reg;
        byte_next  = byte_reg;
        shreg_next = shreg_reg;
        tx_next    = 1'b1;
        conv_start = 1'b0;
`ifdef SCORE_UART_TX_PARITY_EN
        par_next   = par_reg;
`endif
        baud_end   = (baud_reg == BAUD_LAST);

        case (state_reg)
            IDLE: begin
                if (send) begin
                    conv_start = 1'b1;
                    byte_next  = '0;
                    state_next = CONV;
                end
            end
            CONV: begin
                if (conv_done) begin
                    state_next = LOAD;
                end
            end
            LOAD: begin
                shreg_next = msg_bytes[byte_reg];
`ifdef SCORE_UART_TX_PARITY_EN
                par_next   = ^msg_bytes[byte_reg];
`endif
                baud_next  = '0;
                state_next = START;
            end
            START: begin
                tx_next = 1'b0;
                if (baud_end) begin
                    baud_next  = '0;
                    bit_next   = '0;
                    state_next = DATA;
                end else begin
                    baud_next = baud_reg + BAUD_W'(1);
                end
            end
            DATA: begin
                tx_next = shreg_reg[0];
                if (baud_end) begin
                    baud_next  = '0;
                    shreg_next = shreg_reg >> 1;
                    if (bit_reg == 3'd7) begin
`ifdef SCORE_UART_TX_PARITY_EN
                        state_next = PARITY;
`else
                        state_next = STOP;
`endif
                    end else begin
                        bit_next = bit_reg + 3'd1;
                    end
                end else begin
                    baud_next = baud_reg + BAUD_W'(1);
                end
            end
`ifdef SCORE_UART_TX_PARITY_EN
            PARITY: begin
                tx_next = par_reg;
                if (baud_end) begin
                    baud_next  = '0;
                    state_next = STOP;
                end else begin
                    baud_next = baud_reg + BAUD_W'(1);
                end
            end
`endif
            STOP: begin
                tx_next = 1'b1;
                if (baud_end) begin
                    baud_next = '0;
                    if (byte_reg == BYTE_LAST) begin
                        byte_next  = '0;
                        state_next = IDLE;
                    end else begin
                        byte_next  = byte_reg + BYTE_W'(1);
                        state_next = LOAD;
                    end
                end else begin
                    baud_next = baud_reg + BAUD_W'(1);
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign busy = (state_reg != IDLE);
    assign tx   = tx_reg;

endmodule

// File: tb/tb_score_uart_tx.sv
// Self-checking bench for score_uart_tx: table of scores with expected ASCII
// messages, plus sequences for send-while-busy and mid-frame reset.
module tb_score_uart_tx;

    localparam int BAUD_DIV = 104;
`ifdef SCORE_UART_TX_PARITY_EN
    localparam int NCELL = 11;
`else
    localparam int NCELL = 10;
`endif
    localparam int MSG_LEN = 9 * (NCELL * BAUD_DIV + 1) + 20;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [19:0] score = '0;
    logic        send = 1'b0;
    logic        busy;
    logic        tx;

    int cyc = 0;
    int n_checks = 0;
    int n_pass = 0;

    typedef struct {
        logic [19:0] score;
        logic [71:0] msg;
    } vec_t;

    vec_t vecs [3];

    score_uart_tx #(
        .CLK_HZ (12000000),
        .BAUD   (115200),
        .DIGITS (7)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .score (score),
        .send  (send),
        .busy  (busy),
        .tx    (tx)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete, got timeout required finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input int got, input int exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d (0x%0h) required %0d (0x%0h)", name, got, got, exp, exp);
    endtask

    task automatic send_score(input logic [19:0] s, output int t_ref);
        @(negedge clk);
        chk("busy_before_send", int'(busy), 0);
        score = s;
        send  = 1'b1;
        @(negedge clk);
        send  = 1'b0;
        score = ~s;
        t_ref = cyc;
        chk("busy_after_send", int'(busy), 1);
    endtask

    task automatic wait_fall(input int bound, output int at, output bit ok);
        ok = 1'b0;
        at = cyc;
        for (int n = 0; n <= bound; n++) begin
            if (tx === 1'b0) begin
                ok = 1'b1;
                at = cyc;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic recv_msg(input int t_ref, input logic [71:0] msg, input string tag);
        int prev_end;
        int fall_at;
        bit ok;
        prev_end = 0;
        for (int b = 0; b < 9; b++) begin
            logic [7:0]       eb;
            logic [7:0]       got;
            logic [NCELL-1:0] frame;
            int               bad;
            eb = msg[(8-b)*8 +: 8];
`ifdef SCORE_UART_TX_PARITY_EN
            frame = {1'b1, ^eb, eb, 1'b0};
`else
            frame = {1'b1, eb, 1'b0};
`endif
            wait_fall((b == 0) ? 40 : 10, fall_at, ok);
            chk($sformatf("%s_start%0d_seen", tag, b), int'(ok), 1);
            if (!ok) return;
            if (b == 0) chk($sformatf("%s_first_start", tag), fall_at - t_ref, 22);
            else        chk($sformatf("%s_gap%0d", tag, b), fall_at - prev_end, 2);
            got = '0;
            bad = 0;
            for (int c = 0; c < NCELL; c++) begin
                for (int j = 0; j < BAUD_DIV; j++) begin
                    if (c != 0 || j != 0) @(negedge clk);
                    if (tx !== frame[c]) bad++;
                    if (j == BAUD_DIV / 2 && c >= 1 && c <= 8) got[c-1] = tx;
                end
            end
            prev_end = cyc;
            chk($sformatf("%s_byte%0d", tag, b), int'(got), int'(eb));
            chk($sformatf("%s_bitwidth%0d", tag, b), bad, 0);
        end
        for (int n = 0; n < 50; n++) begin
            if (busy === 1'b0) break;
            @(negedge clk);
        end
        chk($sformatf("%s_busy_len", tag), cyc - t_ref, MSG_LEN);
    endtask

    task automatic quiet_check(input int ncyc, input string name);
        int bad;
        bad = 0;
        repeat (ncyc) begin
            @(negedge clk);
            if (tx !== 1'b1 || busy !== 1'b0) bad++;
        end
        chk(name, bad, 0);
    endtask

    initial begin
        int t0;
        int t1;
        int bad;

        vecs[0].score = 20'd1000004; vecs[0].msg = 72'h31_30_30_30_30_30_34_0D_0A;
        vecs[1].score = 20'd0;       vecs[1].msg = 72'h30_30_30_30_30_30_30_0D_0A;
        vecs[2].score = 20'd3;       vecs[2].msg = 72'h30_30_30_30_30_30_33_0D_0A;

        // Power-on reset
        #2 rst_n = 1'b0;
        #1;
        chk("reset_tx", int'(tx), 1);
        chk("reset_busy", int'(busy), 0);
        repeat (3) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        quiet_check(10, "idle_after_reset");

        // Reset in the middle of byte 4's data bits
        send_score(20'd987650, t0);
        while (cyc < t0 + 22 + 4 * (NCELL * BAUD_DIV + 1) + BAUD_DIV + 400) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midreset_tx", int'(tx), 1);
        chk("midreset_busy", int'(busy), 0);
        bad = 0;
        repeat (3) begin
            @(negedge clk);
            if (tx !== 1'b1 || busy !== 1'b0) bad++;
        end
        chk("midreset_hold", bad, 0);
        rst_n = 1'b1;
        quiet_check(300, "midreset_no_edges");

        // Table-driven messages (the first is also the fresh message after reset)
        for (int i = 0; i < 3; i++) begin
            send_score(vecs[i].score, t0);
            recv_msg(t0, vecs[i].msg, $sformatf("vec%0d", i));
            $display("vec%0d score=%0d sent, checks so far %0d", i, vecs[i].score, n_checks);
        end

        // Send pulses while busy (ignored), one on the cycle busy falls (ignored),
        // and one on the following cycle (accepted with the new score).
        send_score(20'd1048575, t0);
        t1 = t0 + MSG_LEN + 1;
        fork
            begin
                recv_msg(t0, 72'h31_30_34_38_35_37_35_0D_0A, "busyA");
                recv_msg(t1, 72'h30_31_32_33_34_35_36_0D_0A, "busyB");
            end
            begin
                int ks [6] = '{5, 21, 22, 500, 4000, 8400};
                for (int p = 0; p < 6; p++) begin
                    while (cyc < t0 + ks[p] - 1) @(negedge clk);
                    score = 20'($urandom_range(0, 1048575));
                    send  = 1'b1;
                    @(negedge clk);
                    send  = 1'b0;
                end
                while (cyc < t0 + MSG_LEN - 1) @(negedge clk);
                score = 20'd123456;
                send  = 1'b1;
                @(negedge clk);
                @(negedge clk);
                send  = 1'b0;
                score = 20'd777777;
            end
        join
        quiet_check(200, "no_queued_message");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
